// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// Each operation goes accept (IDLE) -> EXEC -> RESP. Operands and result are
// registered, and the ALU pins are always driven from the operand registers.
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN. When it is defined, ties are
// broken round-robin using LAST_GRANT. When it is undefined, port 0 always wins.
module alu_share_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FUN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    input  logic [FUN_W-1:0] REQ0_FUN,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    input  logic [FUN_W-1:0] REQ1_FUN,
    output logic             RSP0_VALID,
    input  logic             RSP0_READY,
    output logic [WIDTH-1:0] RSP0_RESULT,
    output logic             RSP1_VALID,
    input  logic             RSP1_READY,
    output logic [WIDTH-1:0] RSP1_RESULT,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [FUN_W-1:0] ALU_FUN,
    input  logic [WIDTH-1:0] ALU_RESULT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [FUN_W-1:0]   fun_q, fun_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               any_valid_c;
    logic               grant_c;
    logic               accept_c;
    logic               rsp_ready_c;
    logic               rsp_done_c;

    assign any_valid_c = REQ0_VALID | REQ1_VALID;
    assign accept_c    = (state_q == S_IDLE) && any_valid_c && !RST;
    assign rsp_ready_c = grant_q ? RSP1_READY : RSP0_READY;
    assign rsp_done_c  = (state_q == S_RESP) && rsp_ready_c;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Grant selection: on a tie, serve the port that did not go last
    always_comb begin
        grant_c = !REQ0_VALID;
        if (REQ0_VALID && REQ1_VALID) begin
            grant_c = !last_grant_q;
        end
    end

    // Remember who completed last; updated only on a response handshake
    always_comb begin
        last_grant_d = last_grant_q;
        if (rsp_done_c) begin
            last_grant_d = grant_q;
        end
    end

    // Round-robin history register; resets to 1 so port 0 wins the first tie
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Grant selection: fixed priority, port 1 only when port 0 is idle
    always_comb begin
        grant_c = !REQ0_VALID;
    end
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_valid_c) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request READY only in IDLE outside reset, response VALID only in RESP
    always_comb begin
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP0_VALID = 1'b0;
        RSP1_VALID = 1'b0;
        if (accept_c) begin
            REQ0_READY = !grant_c;
            REQ1_READY = grant_c;
        end
        if (state_q == S_RESP) begin
            RSP0_VALID = !grant_q;
            RSP1_VALID = grant_q;
        end
    end

    // Datapath next values: capture operands on accept and the ALU result in EXEC
    always_comb begin
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        fun_d    = fun_q;
        result_d = result_q;
        if (accept_c) begin
            grant_d = grant_c;
            a_d     = grant_c ? REQ1_A   : REQ0_A;
            b_d     = grant_c ? REQ1_B   : REQ0_B;
            fun_d   = grant_c ? REQ1_FUN : REQ0_FUN;
        end
        if (state_q == S_EXEC) begin
            result_d = ALU_RESULT;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            result_q <= '0;
        end else begin
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            result_q <= result_d;
        end
    end

    assign ALU_A       = a_q;
    assign ALU_B       = b_q;
    assign ALU_FUN     = fun_q;
    assign RSP0_RESULT = result_q;
    assign RSP1_RESULT = result_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb with a small reference ALU attached.
// Tie-break expectations follow ALU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_alu_share_arb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FUN_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
    logic [WIDTH-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [FUN_W-1:0] REQ0_FUN, REQ1_FUN;
    logic             RSP0_VALID, RSP0_READY, RSP1_VALID, RSP1_READY;
    logic [WIDTH-1:0] RSP0_RESULT, RSP1_RESULT;
    logic [WIDTH-1:0] ALU_A, ALU_B, ALU_RESULT;
    logic [FUN_W-1:0] ALU_FUN;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    alu_share_arb #(.WIDTH(WIDTH), .FUN_W(FUN_W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
        .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_RESULT(RSP0_RESULT),
        .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_RESULT(RSP1_RESULT),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_RESULT(ALU_RESULT)
    );

    // Reference ALU: add, sub, slt, sra; every other code returns 0
    always_comb begin
        ALU_RESULT = '0;
        case (ALU_FUN)
            4'b0000: ALU_RESULT = ALU_A + ALU_B;
            4'b1000: ALU_RESULT = ALU_A - ALU_B;
            4'b0010: ALU_RESULT = WIDTH'($signed(ALU_A) < $signed(ALU_B));
            4'b1101: ALU_RESULT = WIDTH'($signed(ALU_A) >>> ALU_B[4:0]);
            default: ALU_RESULT = '0;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        REQ0_VALID = 1'b0; REQ0_A = '0; REQ0_B = '0; REQ0_FUN = '0;
        REQ1_VALID = 1'b0; REQ1_A = '0; REQ1_B = '0; REQ1_FUN = '0;
        RSP0_READY = 1'b0; RSP1_READY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        RST = 1'b1;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        #2;
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b00)
            $display("FAIL reset_ready: got %b expected 00", {REQ0_READY, REQ1_READY});
        else n_pass++;
        n_checks++;
        if ({RSP0_VALID, RSP1_VALID} !== 2'b00)
            $display("FAIL reset_rsp_valid: got %b expected 00", {RSP0_VALID, RSP1_VALID});
        else n_pass++;
        n_checks++;
        if ({ALU_A, ALU_B, ALU_FUN, RSP0_RESULT} !== '0)
            $display("FAIL reset_regs: got a=%h b=%h f=%h r=%h expected all 0",
                     ALU_A, ALU_B, ALU_FUN, RSP0_RESULT);
        else n_pass++;
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_single_add();
        apply_reset();
        REQ0_VALID = 1'b1; REQ0_A = 32'd5; REQ0_B = 32'd3; REQ0_FUN = 4'b0000;
        RSP0_READY = 1'b1;
        #1;
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10)
            $display("FAIL add_accept_ready: got %b expected 10", {REQ0_READY, REQ1_READY});
        else n_pass++;
        tick();
        REQ0_VALID = 1'b0;
        #1;
        n_checks++;
        if (ALU_A !== 32'd5 || ALU_B !== 32'd3 || RSP0_VALID !== 1'b0 || REQ0_READY !== 1'b0)
            $display("FAIL add_exec: got a=%h b=%h v=%b rdy=%b expected a=5 b=3 v=0 rdy=0",
                     ALU_A, ALU_B, RSP0_VALID, REQ0_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP0_VALID !== 1'b1 || RSP0_RESULT !== 32'd8 || RSP1_VALID !== 1'b0)
            $display("FAIL add_resp: got v0=%b r=%h v1=%b expected v0=1 r=8 v1=0",
                     RSP0_VALID, RSP0_RESULT, RSP1_VALID);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP0_VALID !== 1'b0)
            $display("FAIL add_release: got v0=%b expected 0", RSP0_VALID);
        else n_pass++;
    endtask

    task automatic test_tie();
        apply_reset();
        RSP0_READY = 1'b1; RSP1_READY = 1'b1;
        REQ0_VALID = 1'b1; REQ0_A = 32'd10; REQ0_B = 32'd4; REQ0_FUN = 4'b1000;
        REQ1_VALID = 1'b1; REQ1_A = 32'h8000_0000; REQ1_B = 32'd4; REQ1_FUN = 4'b1101;
        #1;
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10)
            $display("FAIL tie_first_grant: got %b expected 10", {REQ0_READY, REQ1_READY});
        else n_pass++;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        n_checks++;
        if (RSP0_VALID !== 1'b1 || RSP0_RESULT !== 32'd6 || REQ1_READY !== 1'b0)
            $display("FAIL tie_p0_resp: got v0=%b r=%h rdy1=%b expected v0=1 r=6 rdy1=0",
                     RSP0_VALID, RSP0_RESULT, REQ1_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (REQ1_READY !== 1'b1)
            $display("FAIL tie_p1_accept: got %b expected 1", REQ1_READY);
        else n_pass++;
        tick();
        REQ1_VALID = 1'b0;
        tick();
        n_checks++;
        if (RSP1_VALID !== 1'b1 || RSP1_RESULT !== 32'hF800_0000 || RSP0_VALID !== 1'b0)
            $display("FAIL tie_p1_resp: got v1=%b r=%h v0=%b expected v1=1 r=f8000000 v0=0",
                     RSP1_VALID, RSP1_RESULT, RSP0_VALID);
        else n_pass++;
        tick();
        // Second tie: port 1 went last, so port 0 wins in both modes
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        #1;
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10)
            $display("FAIL tie_second_grant: got %b expected 10", {REQ0_READY, REQ1_READY});
        else n_pass++;
        tick();
        tick();
        tick();
        // Third tie right after port 0 completed: the two modes diverge here
        #1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b01)
            $display("FAIL tie_third_grant: got %b expected 01", {REQ0_READY, REQ1_READY});
        else n_pass++;
`else
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10)
            $display("FAIL fixed_prio_grant: got %b expected 10", {REQ0_READY, REQ1_READY});
        else n_pass++;
        tick();
        tick();
        tick();
        REQ0_VALID = 1'b0;
        #1;
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b01)
            $display("FAIL fixed_prio_p1_after_drop: got %b expected 01", {REQ0_READY, REQ1_READY});
        else n_pass++;
`endif
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    endtask

    task automatic test_back_pressure();
        apply_reset();
        REQ0_VALID = 1'b1; REQ0_A = 32'hFFFF_FFFF; REQ0_B = 32'd1; REQ0_FUN = 4'b0010;
        REQ1_VALID = 1'b1; REQ1_A = 32'd1; REQ1_B = 32'd2; REQ1_FUN = 4'b0000;
        RSP1_READY = 1'b1;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (RSP0_VALID !== 1'b1 || RSP0_RESULT !== 32'd1 || REQ1_READY !== 1'b0)
                $display("FAIL bp_hold_%0d: got v0=%b r=%h rdy1=%b expected v0=1 r=1 rdy1=0",
                         i, RSP0_VALID, RSP0_RESULT, REQ1_READY);
            else n_pass++;
            tick();
        end
        RSP0_READY = 1'b1;
        #1;
        n_checks++;
        if (RSP0_VALID !== 1'b1 || REQ1_READY !== 1'b0)
            $display("FAIL bp_handshake: got v0=%b rdy1=%b expected v0=1 rdy1=0",
                     RSP0_VALID, REQ1_READY);
        else n_pass++;
        tick();
        n_checks++;
        if (REQ1_READY !== 1'b1 || RSP0_VALID !== 1'b0)
            $display("FAIL bp_p1_accept: got rdy1=%b v0=%b expected rdy1=1 v0=0",
                     REQ1_READY, RSP0_VALID);
        else n_pass++;
        tick();
        REQ1_VALID = 1'b0;
        tick();
        n_checks++;
        if (RSP1_VALID !== 1'b1 || RSP1_RESULT !== 32'd3)
            $display("FAIL bp_p1_resp: got v1=%b r=%h expected v1=1 r=3", RSP1_VALID, RSP1_RESULT);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_exec();
        apply_reset();
        REQ1_VALID = 1'b1; REQ1_A = 32'd7; REQ1_B = 32'd8; REQ1_FUN = 4'b0000;
        RSP1_READY = 1'b1; RSP0_READY = 1'b1;
        tick();
        REQ1_VALID = 1'b0;
        #1;
        n_checks++;
        if (ALU_A !== 32'd7)
            $display("FAIL rst_exec_operand: got %h expected 7", ALU_A);
        else n_pass++;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({ALU_A, ALU_B, ALU_FUN} !== '0 || RSP1_VALID !== 1'b0)
            $display("FAIL rst_async_clear: got a=%h b=%h f=%h v1=%b expected 0",
                     ALU_A, ALU_B, ALU_FUN, RSP1_VALID);
        else n_pass++;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({RSP0_VALID, RSP1_VALID} !== 2'b00)
                $display("FAIL rst_no_resp_%0d: got %b expected 00", i, {RSP0_VALID, RSP1_VALID});
            else n_pass++;
        end
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        #1;
        n_checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10)
            $display("FAIL rst_first_tie: got %b expected 10", {REQ0_READY, REQ1_READY});
        else n_pass++;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    endtask

    task automatic test_unsupported();
        apply_reset();
        RSP0_READY = 1'b1; RSP1_READY = 1'b1;
        REQ0_VALID = 1'b1; REQ0_A = 32'd1; REQ0_B = 32'd2; REQ0_FUN = 4'b0000;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        n_checks++;
        if (RSP0_RESULT !== 32'd3)
            $display("FAIL unsup_prior_add: got %h expected 3", RSP0_RESULT);
        else n_pass++;
        tick();
        REQ1_VALID = 1'b1; REQ1_A = 32'd123; REQ1_B = 32'd456; REQ1_FUN = 4'b1111;
        tick();
        REQ1_VALID = 1'b0;
        n_checks++;
        if (ALU_FUN !== 4'b1111 || RSP1_VALID !== 1'b0)
            $display("FAIL unsup_exec: got f=%h v1=%b expected f=f v1=0", ALU_FUN, RSP1_VALID);
        else n_pass++;
        tick();
        n_checks++;
        if (RSP1_VALID !== 1'b1 || RSP1_RESULT !== 32'd0)
            $display("FAIL unsup_resp: got v1=%b r=%h expected v1=1 r=0", RSP1_VALID, RSP1_RESULT);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_back_pressure();
        test_reset_mid_exec();
        test_unsupported();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
